uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8: width of received characters and FIFO entries.
REQ-002 Parameter DIV_W, default 16: width of baud divisor.
REQ-003 Parameter FIFO_DEPTH, default 4: RX FIFO entries, power of two >= 2.
REQ-004 Parameter TO_TICKS, default 640: oversample ticks of silence before timeout (40 bit-times at 16x).
REQ-005 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  enables tick generation and character acceptance.
REQ-007 div  in  DIV_W  baud divisor; one s_tick every div+1 clk cycles.
REQ-008 s_tick  out  1  oversample tick to the receiver core.
REQ-009 rx_done_tick  in  1  one-cycle strobe from receiver core, character valid.
REQ-010 rx_data  in  DATA_BITS  received character, valid with rx_done_tick.
REQ-011 rd_req  in  1  host pop request.
REQ-012 rd_data  out  DATA_BITS  FIFO head, first-word fall-through.
REQ-013 rd_valid  out  1  FIFO non-empty.
REQ-014 level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 thresh  in  clog2(FIFO_DEPTH)+1  irq level threshold; 0 disables level irq.
REQ-016 overrun  out  1  sticky overrun flag; clr_ovr  in  1  clears it.
REQ-017 irq  out  1  interrupt request.

Function
REQ-018 Baud counter: en=0 -> counter 0, s_tick 0; en=1 -> counter increments each cycle; when counter >= div, s_tick=1 for that cycle and counter -> 0 next cycle.
REQ-019 div change mid-count takes effect immediately via >= compare; div=0 -> s_tick every cycle while en=1.
REQ-020 rx_done_tick with en=1 and FIFO not full: rx_data written at tail, level+1 next cycle.
REQ-021 rx_done_tick with FIFO full and no accepted pop: character discarded, overrun=1 next cycle; contents unchanged.
REQ-022 rx_done_tick with en=0: ignored, no overrun.
REQ-023 rd_req with rd_valid=1: head removed, level-1 next cycle; rd_req while empty ignored.
REQ-024 Simultaneous push and pop: both performed, level unchanged, including when full (no overrun) ; when empty, only push performed.
REQ-025 Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH nor underflows.
REQ-026 overrun stays set until clr_ovr=1; clr_ovr concurrent with new overrun event -> overrun stays 1.
REQ-027 irq = (thresh!=0 and level>=thresh) or overrun or timeout (timeout 0 when feature absent); registered-free combinational OR of registered terms.

Reset
REQ-028 reset asserted: counter 0, s_tick 0, FIFO empty (level 0, rd_valid 0), rd_data 0, overrun 0, timeout state TO_IDLE, irq 0; effect immediate, regardless of operation in progress.
REQ-029 Characters in FIFO at reset are lost; no pop or push completes in the reset cycle.

Configuration
REQ-030 Macro UART_RX_CTRL_TIMEOUT_EN defined: timeout FSM present; undefined: FSM, counter absent, timeout term constant 0.
REQ-031 FSM states TO_IDLE, TO_COUNT, TO_FLAG; TO_IDLE -> TO_COUNT when level!=0.
REQ-032 TO_COUNT: counter increments per s_tick; reset to 0 on accepted push; -> TO_FLAG when counter reaches TO_TICKS-1 on s_tick; -> TO_IDLE if level becomes 0.
REQ-033 TO_FLAG: timeout=1; -> TO_COUNT (counter 0) on accepted push or pop leaving level!=0; -> TO_IDLE when level becomes 0.

Structure
REQ-034 Package uart_rx_ctrl_pkg holds timeout state typedef, default parameter constants, level width function.
REQ-035 FIFO storage and pointers in one sub-module, uart_rx_fifo; baud counter and timeout FSM in top.

Verification
REQ-036 div=3, en=1 -> s_tick on every 4th cycle; en=0 -> s_tick 0 and counter 0 within one cycle.
REQ-037 Push 0x41,0x42,0x43 -> level 3, rd_data 0x41; pop thrice -> 0x41,0x42,0x43 then rd_valid 0.
REQ-038 Fill 4 entries, push 0x55 -> overrun 1, FIFO unchanged; push+pop same cycle when full -> no overrun, level 4; clr_ovr -> overrun 0.
REQ-039 thresh=2: one push -> irq 0; second push -> irq 1; pop -> irq 0.
REQ-040 With UART_RX_CTRL_TIMEOUT_EN, div=0, TO_TICKS=640: one push, no activity -> irq 1 after 640 s_ticks; pop to empty -> irq 0; reset mid-count -> all outputs reset values.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared types and constants for the UART RX controller
//
// Purpose: timeout FSM state type, default parameter values and the
//          FIFO level-width helper used by uart_rx_ctrl and uart_rx_fifo.
// Ports:   none (package).
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FLAG  = 2'd2
  } to_state_e;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_DIV_W      = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TO_TICKS   = 640;

  // Occupancy must be able to represent DEPTH itself, hence the extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through RX character FIFO
//
// Purpose: stores received characters; push/pop are requests that the FIFO
//          qualifies itself (pop only when non-empty, push when not full or
//          when a pop frees a slot in the same cycle).
// Ports:   clk, reset (async, active-high)
//          push, wdata          - push request and character
//          pop                  - pop request
//          rd_data, rd_valid    - head entry (0 when empty), non-empty flag
//          level, level_next    - occupancy now and after this cycle
//          full                 - level == DEPTH
//          push_acc, pop_acc    - push/pop actually performed this cycle
module uart_rx_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_BITS-1:0]        wdata,
  input  logic                        pop,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic [level_w(DEPTH)-1:0]   level_next,
  output logic                        full,
  output logic                        push_acc,
  output logic                        pop_acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [LW-1:0]        level_q, level_d;

  assign full     = (level_q == LW'(DEPTH));
  assign rd_valid = (level_q != '0);
  assign pop_acc  = pop & rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_acc = push & (~full | pop_acc);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_acc) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign rd_data    = rd_valid ? mem_q[rptr_q] : '0;
  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud tick, RX FIFO, irq
//
// Purpose: generates the oversample tick for the receiver core, buffers
//          received characters in uart_rx_fifo, tracks sticky overrun and
//          raises irq on level threshold, overrun or RX timeout.
//          Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (timeout FSM).
// Ports:   clk, reset (async, active-high), en
//          div / s_tick                 - baud divisor and oversample tick
//          rx_done_tick / rx_data       - character strobe from receiver core
//          rd_req / rd_data / rd_valid  - host pop and FIFO head
//          level, thresh                - occupancy and irq level threshold
//          overrun, clr_ovr             - sticky overrun flag and its clear
//          irq                          - interrupt request
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TO_TICKS   = DEF_TO_TICKS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [DIV_W-1:0]                 div,
  output logic                             s_tick,
  input  logic                             rx_done_tick,
  input  logic [DATA_BITS-1:0]             rx_data,
  input  logic                             rd_req,
  output logic [DATA_BITS-1:0]             rd_data,
  output logic                             rd_valid,
  output logic [level_w(FIFO_DEPTH)-1:0]   level,
  input  logic [level_w(FIFO_DEPTH)-1:0]   thresh,
  output logic                             overrun,
  input  logic                             clr_ovr,
  output logic                             irq
);

  localparam int LW = level_w(FIFO_DEPTH);

  // Baud counter. The >= compare lets a lowered div take effect at once.
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign s_tick = en & ~reset & (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || s_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // FIFO
  logic          push_req;
  logic          full;
  logic          push_acc;
  logic          pop_acc;
  logic [LW-1:0] level_next;

  assign push_req = en & rx_done_tick;

  uart_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_req),
    .wdata      (rx_data),
    .pop        (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .level_next (level_next),
    .full       (full),
    .push_acc   (push_acc),
    .pop_acc    (pop_acc)
  );

  // Sticky overrun; a new event wins over a concurrent clear.
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q & ~clr_ovr;
    if (push_req && full && !pop_acc) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;

  // RX timeout
  logic timeout;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TO_CW = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;

  to_state_e        to_state_q, to_state_d;
  logic [TO_CW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_state_d = to_state_q;
    to_cnt_d   = to_cnt_q;
    case (to_state_q)
      TO_IDLE: begin
        to_cnt_d = '0;
        if (level != '0) to_state_d = TO_COUNT;
      end
      TO_COUNT: begin
        if (level_next == '0) begin
          to_state_d = TO_IDLE;
          to_cnt_d   = '0;
        end else if (push_acc) begin
          to_cnt_d = '0;
        end else if (s_tick) begin
          if (to_cnt_q == TO_CW'(TO_TICKS - 1)) begin
            to_state_d = TO_FLAG;
            to_cnt_d   = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      TO_FLAG: begin
        if (level_next == '0) begin
          to_state_d = TO_IDLE;
          to_cnt_d   = '0;
        end else if (push_acc || pop_acc) begin
          to_state_d = TO_COUNT;
          to_cnt_d   = '0;
        end
      end
      default: begin
        to_state_d = TO_IDLE;
        to_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_state_q <= TO_IDLE;
      to_cnt_q   <= '0;
    end else begin
      to_state_q <= to_state_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign timeout = (to_state_q == TO_FLAG);
`else
  logic unused_to;

  assign timeout   = 1'b0;
  assign unused_to = ^{push_acc, level_next};
`endif

  assign irq = ((thresh != '0) && (level >= thresh)) | overrun_q | timeout;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] div;
  logic        s_tick;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  level;
  logic [2:0]  thresh;
  logic        overrun;
  logic        clr_ovr;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_ctrl #(
    .DATA_BITS  (8),
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .TO_TICKS   (640)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .div          (div),
    .s_tick       (s_tick),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .level        (level),
    .thresh       (thresh),
    .overrun      (overrun),
    .clr_ovr      (clr_ovr),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_data      = d;
    rx_done_tick = 1'b1;
    cyc();
    rx_done_tick = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_level"},    level,    3'd0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_data"},  rd_data,  8'h00);
    chk({tag, "_overrun"},  overrun,  1'b0);
    chk({tag, "_irq"},      irq,      1'b0);
    chk({tag, "_s_tick"},   s_tick,   1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    en           = 1'b1;
    div          = 16'd0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    rd_req       = 1'b0;
    thresh       = 3'd0;
    clr_ovr      = 1'b0;

    // Reset state, with en=1/div=0 that would otherwise tick every cycle
    cyc();
    cyc();
    chk_reset_outputs("rst");
    en = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_s_tick", s_tick, 1'b0);

    // Baud tick: div=3 -> tick on every 4th cycle
    div = 16'd3;
    en  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("div3_tick_%0d", i), s_tick, (i % 4) == 3);
      if (i < 8) cyc();
    end
    cyc();
    cyc();
    en = 1'b0;
    #1;
    chk("en0_s_tick", s_tick, 1'b0);
    cyc();
    en = 1'b1;
    // Counter must have restarted from 0
    chk("restart_0", s_tick, 1'b0);
    cyc();
    chk("restart_1", s_tick, 1'b0);
    cyc();
    chk("restart_2", s_tick, 1'b0);
    cyc();
    chk("restart_3", s_tick, 1'b1);
    div = 16'd0;
    cyc();
    chk("div0_a", s_tick, 1'b1);
    cyc();
    chk("div0_b", s_tick, 1'b1);

    // Keep s_tick quiet during FIFO tests
    div = 16'hFFFF;

    // Push three, pop three
    push(8'h41);
    push(8'h42);
    push(8'h43);
    chk("p3_level",    level,    3'd3);
    chk("p3_rd_data",  rd_data,  8'h41);
    chk("p3_rd_valid", rd_valid, 1'b1);
    pop();
    chk("pop1_data",  rd_data, 8'h42);
    chk("pop1_level", level,   3'd2);
    pop();
    chk("pop2_data",  rd_data, 8'h43);
    pop();
    chk("pop3_valid", rd_valid, 1'b0);
    chk("pop3_level", level,    3'd0);
    chk("pop3_data",  rd_data,  8'h00);
    pop();
    chk("pop_empty_level", level, 3'd0);

    // Character ignored while disabled
    en = 1'b0;
    push(8'h99);
    chk("en0_level",   level,   3'd0);
    chk("en0_overrun", overrun, 1'b0);
    en = 1'b1;

    // Fill, overrun, clear, full push+pop
    push(8'h10);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    chk("full_level", level,   3'd4);
    chk("full_irq",   irq,     1'b0);
    push(8'h55);
    chk("ovr_set",   overrun, 1'b1);
    chk("ovr_level", level,   3'd4);
    chk("ovr_head",  rd_data, 8'h10);
    chk("ovr_irq",   irq,     1'b1);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    chk("ovr_clr",     overrun, 1'b0);
    chk("ovr_clr_irq", irq,     1'b0);
    rx_data      = 8'h66;
    rx_done_tick = 1'b1;
    rd_req       = 1'b1;
    cyc();
    rx_done_tick = 1'b0;
    rd_req       = 1'b0;
    chk("pp_full_overrun", overrun, 1'b0);
    chk("pp_full_level",   level,   3'd4);
    chk("pp_full_head",    rd_data, 8'h11);
    // A clear that coincides with a new overrun loses
    clr_ovr = 1'b1;
    push(8'h77);
    clr_ovr = 1'b0;
    chk("ovr_clr_race", overrun, 1'b1);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    chk("ovr_clr2", overrun, 1'b0);
    // Drain across the pointer wrap
    pop();
    chk("drain_12", rd_data, 8'h12);
    pop();
    chk("drain_13", rd_data, 8'h13);
    pop();
    chk("drain_66", rd_data, 8'h66);
    pop();
    chk("drain_empty", rd_valid, 1'b0);

    // Push+pop while empty: only the push happens
    rx_data      = 8'h5A;
    rx_done_tick = 1'b1;
    rd_req       = 1'b1;
    cyc();
    rx_done_tick = 1'b0;
    rd_req       = 1'b0;
    chk("pp_empty_level", level,   3'd1);
    chk("pp_empty_data",  rd_data, 8'h5A);
    pop();
    chk("pp_empty_drain", level, 3'd0);

    // Level threshold irq
    thresh = 3'd2;
    push(8'h01);
    chk("th_one", irq, 1'b0);
    push(8'h02);
    chk("th_two", irq, 1'b1);
    pop();
    chk("th_pop", irq, 1'b0);
    pop();
    thresh = 3'd0;

    // Asynchronous reset mid-operation
    push(8'hA5);
    push(8'hA6);
    chk("pre_rst_level", level, 3'd2);
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_level", level, 3'd0);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    // Timeout after 640 s_ticks of silence
    div = 16'd0;
    push(8'h21);
    for (int i = 0; i < 640; i++) cyc();
    chk("to_before", irq, 1'b0);
    cyc();
    chk("to_fire", irq, 1'b1);
    pop();
    chk("to_empty_irq", irq, 1'b0);
    push(8'h22);
    for (int i = 0; i < 300; i++) cyc();
    reset = 1'b1;
    #1;
    chk_reset_outputs("to_rst");
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 700; i++) cyc();
    chk("to_after_rst_irq", irq, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
